// File: rtl/sid_bus_master.sv
// rtl/sid_bus_master.sv - SID shadow register file with phi2-synchronous write replay
module sid_bus_master #(
    parameter int PHI2_DIV    = 16,
    parameter int NUM_REGS    = 25,
    parameter int SID_RST_CYC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] addr,
    input  logic [7:0] data,
    input  logic       write_en,
    input  logic       data_rdy,
    output logic       phi2,
    output logic       sid_rst_n,
    output logic       sid_cs_n,
    output logic       sid_rw,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       sid_data_oe,
    output logic       busy
);

    localparam int DW = $clog2(PHI2_DIV);
    localparam int PW = $clog2(NUM_REGS + 1);
    localparam int IW = $clog2(SID_RST_CYC + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCAN,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DW-1:0]        div_cnt;
    logic [DW-1:0]        div_nxt;
    logic                 cyc_end;
    logic [IW-1:0]        init_cnt;
    logic                 write_en_d;
    logic                 we_rise;
    logic [7:0]           shadow [NUM_REGS];
    logic [NUM_REGS-1:0]  dirty;
    logic [NUM_REGS-1:0]  set_mask;
    logic [NUM_REGS-1:0]  clr_mask;
    logic                 pending;
    logic [PW-1:0]        ptr;

    logic init_tick;
    logic init_done;
    logic accept;
    logic ptr_inc;
    logic load_bus;
    logic end_write;

    // cyc_end marks the clk whose edge wraps div_cnt to 0 (a cycle start)
    assign cyc_end  = (div_cnt == DW'(PHI2_DIV - 1));
    assign div_nxt  = cyc_end ? '0 : div_cnt + 1'b1;
    assign we_rise  = write_en & ~write_en_d;
    assign set_mask = (we_rise && (addr < 5'(NUM_REGS))) ? (NUM_REGS'(1) << addr) : '0;
    assign clr_mask = load_bus ? (NUM_REGS'(1) << ptr) : '0;

    assign sid_rw      = 1'b0;
    assign sid_data_oe = ~sid_cs_n;
    assign busy        = (state != S_IDLE) | pending;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    // next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        init_tick = 1'b0;
        init_done = 1'b0;
        accept    = 1'b0;
        ptr_inc   = 1'b0;
        load_bus  = 1'b0;
        end_write = 1'b0;
        case (state)
            S_INIT: begin
                if (cyc_end) begin
                    init_tick = 1'b1;
                    if (init_cnt == IW'(SID_RST_CYC - 1)) begin
                        init_done = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (pending) begin
                    accept    = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ptr == PW'(NUM_REGS)) state_nxt = S_IDLE;
                else if (dirty[ptr])      state_nxt = S_WAIT;
                else                      ptr_inc   = 1'b1;
            end
            S_WAIT: begin
                if (cyc_end) begin
                    load_bus  = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cyc_end) begin
                    end_write = 1'b1;
                    ptr_inc   = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // phi2 divider; phi2 is registered from the next count so it tracks div_cnt without glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            phi2    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            phi2    <= (div_nxt >= DW'(PHI2_DIV / 2));
        end
    end

    // power-on SID reset, counted in phi2 cycle starts
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= '0;
            sid_rst_n <= 1'b0;
        end else begin
            if (init_tick) init_cnt <= init_cnt + 1'b1;
            if (init_done) sid_rst_n <= 1'b1;
        end
    end

    // write capture into the shadow file; a new write's dirty set beats the scanner's clear
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_d <= 1'b0;
            dirty      <= '0;
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'h00;
        end else begin
            write_en_d <= write_en;
            dirty      <= (dirty & ~clr_mask) | set_mask;
            if (we_rise && (addr < 5'(NUM_REGS))) shadow[addr] <= data;
        end
    end

    // commit request latch and scan pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            ptr     <= '0;
        end else begin
            if (data_rdy)    pending <= 1'b1;
            else if (accept) pending <= 1'b0;
            if (accept)       ptr <= '0;
            else if (ptr_inc) ptr <= ptr + 1'b1;
        end
    end

    // SID bus drive; address and data hold their last values after the cycle ends
    always_ff @(posedge clk) begin
        if (rst) begin
            sid_cs_n <= 1'b1;
            sid_addr <= 5'd0;
            sid_data <= 8'h00;
        end else if (load_bus) begin
            sid_cs_n <= 1'b0;
            sid_addr <= 5'(ptr);
            sid_data <= shadow[ptr];
        end else if (end_write) begin
            sid_cs_n <= 1'b1;
        end
    end

endmodule
